// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and cell width.
// The state values are fixed so the bench and any debug tooling can decode them.
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// Team 4-bit ripple-carry adder cell, reused here as the serial datapath slice.
module Ripple_Carry_Adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] carry;

   // Plain full-adder chain, bit 0 first
   always_comb begin
      carry    = '0;
      s        = '0;
      carry[0] = cin;
      for (int i = 0; i < 4; i++) begin
         s[i]         = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// N x 4-bit adder that reuses one ripple-carry cell per cycle, LSB nibble first,
// with a start/ready/done handshake and registered carry between nibbles.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int N_NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*N_NIBBLES-1:0] a,
   input  logic [4*N_NIBBLES-1:0] b,
   input  logic                   cin,
   output logic                   ready,
   output logic                   busy,
   output logic                   done,
   output logic [4*N_NIBBLES-1:0] sum,
   output logic                   cout,
   output logic                   ovf
);

   localparam int W    = NIBBLE_W * N_NIBBLES;
   localparam int IDXW = $clog2(N_NIBBLES);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NIBBLES - 1);

   state_t          state;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic            carry_r;
   logic [IDXW-1:0] idx;

   logic [3:0]      cell_a;
   logic [3:0]      cell_b;
   logic [3:0]      cell_s;
   logic            cell_cout;

   assign cell_a = op_a[NIBBLE_W*idx +: NIBBLE_W];
   assign cell_b = op_b[NIBBLE_W*idx +: NIBBLE_W];

   Ripple_Carry_Adder_4bit u_cell (
      .a    (cell_a),
      .b    (cell_b),
      .cin  (carry_r),
      .s    (cell_s),
      .cout (cell_cout)
   );

   // Handshake flags are registered alongside the state so they change on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         op_a    <= '0;
         op_b    <= '0;
         carry_r <= 1'b0;
         idx     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_a    <= a;
                  op_b    <= b;
                  carry_r <= cin;
                  sum     <= '0;
                  idx     <= '0;
                  state   <= RUN;
                  ready   <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            RUN: begin
               sum[NIBBLE_W*idx +: NIBBLE_W] <= cell_s;
               carry_r                       <= cell_cout;
               if (idx == LAST_IDX) begin
                  // Top nibble: the cell output is the final sum MSB and carry out
                  cout  <= cell_cout;
                  ovf   <= (op_a[W-1] == op_b[W-1]) && (cell_s[3] != op_a[W-1]);
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               ready <= 1'b1;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomised bench for nibble_serial_adder against an arithmetic
// model: {cout,sum} = a + b + cin, with overflow from the operand sign bits.
module tb_nibble_serial_adder;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks;
   int errors;

   nibble_serial_adder #(.N_NIBBLES(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
      checkOutput({tag, "_busy"},  32'(busy),  32'd0);
      checkOutput({tag, "_done"},  32'(done),  32'd0);
      checkOutput({tag, "_sum"},   32'(sum),   32'd0);
      checkOutput({tag, "_cout"},  32'(cout),  32'd0);
      checkOutput({tag, "_ovf"},   32'(ovf),   32'd0);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
   // keepStart leaves start high for back-to-back use; disturb pulses start with junk
   // operands through RUN and DONE, which must be ignored.
   task automatic applyStimulus(input logic [W-1:0] opA, input logic [W-1:0] opB,
                                input logic opC, input bit keepStart, input bit disturb);
      logic [W:0] full;
      logic       expOvf;
      full   = {1'b0, opA} + {1'b0, opB} + (W+1)'(opC);
      expOvf = (opA[W-1] == opB[W-1]) && (full[W-1] != opA[W-1]);
      checkOutput("ready_before_start", 32'(ready), 32'd1);
      a     = opA;
      b     = opB;
      cin   = opC;
      start = 1'b1;
      for (int k = 1; k <= N + 1; k++) begin
         @(negedge clk);
         a     = W'($urandom);
         b     = W'($urandom);
         cin   = 1'($urandom);
         start = keepStart || disturb;
         if (k <= N) begin
            checkOutput("busy_in_run", 32'(busy), 32'd1);
            checkOutput("no_early_done", 32'(done), 32'd0);
         end else begin
            checkOutput("done_pulse", 32'(done), 32'd1);
            checkOutput("busy_in_done", 32'(busy), 32'd0);
            checkOutput("sum", 32'(sum), 32'(full[W-1:0]));
            checkOutput("cout", 32'(cout), 32'(full[W]));
            checkOutput("ovf", 32'(ovf), 32'(expOvf));
         end
      end
      @(negedge clk);
      checkOutput("ready_after_done", 32'(ready), 32'd1);
      checkOutput("done_single_cycle", 32'(done), 32'd0);
      checkOutput("sum_held", 32'(sum), 32'(full[W-1:0]));
      checkOutput("cout_held", 32'(cout), 32'(full[W]));
      if (!keepStart) start = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      cin    = 1'b0;
      repeat (2) @(negedge clk);
      checkResetValues("reset");
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] directed operations");
      applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1);
      repeat (2) begin
         @(negedge clk);
         checkOutput("idle_no_accept", 32'(ready), 32'd1);
         checkOutput("idle_sum_kept", 32'(sum), 32'h0000);
      end

      $display("[TB] reset during run");
      a     = 16'h00FF;
      b     = 16'h0001;
      cin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkResetValues("abort");
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         checkOutput("abort_no_done", 32'(done), 32'd0);
         checkOutput("abort_idle", 32'(ready), 32'd1);
      end
      applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);

      $display("[TB] back-to-back randomised operations");
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0);
      applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b0);
      end
      start = 1'b0;
      @(negedge clk);
      checkOutput("final_idle", 32'(ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
